// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, data port and downstream sram-like bus around mem_bus_arbiter.
// slave is the arbiter's view; master is the view of the pipeline plus memory around it.
interface mem_bus_arbiter_if;
    logic        flush;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
    logic        busy;

    modport slave (
        input  flush, inst_req, inst_addr,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        output busy
    );

    modport master (
        output flush, inst_req, inst_addr,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter sharing one sram-like bus between instruction fetch and data access.
// One outstanding transaction; fetch responses killed by a flush are swallowed.
module mem_bus_arbiter #(
    parameter logic [1:0] INST_SIZE  = 2'b10,
    parameter bit         DATA_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave mb
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        discard_q, discard_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        pick_data;

    assign pick_data = mb.data_req && (DATA_FIRST || !mb.inst_req);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            discard_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= '0;
            wstrb_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            discard_q <= discard_d;
            wr_q      <= wr_d;
            size_q    <= size_d;
            wstrb_q   <= wstrb_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        discard_d       = discard_q;
        wr_d            = wr_q;
        size_d          = size_q;
        wstrb_d         = wstrb_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        mb.bus_req      = 1'b0;
        mb.inst_addr_ok = 1'b0;
        mb.inst_data_ok = 1'b0;
        mb.data_addr_ok = 1'b0;
        mb.data_data_ok = 1'b0;
        case (state_q)
            IDLE: begin
                if (mb.data_req || mb.inst_req) begin
                    state_d = ADDR;
                    owner_d = pick_data;
                    if (pick_data) begin
                        wr_d    = mb.data_wr;
                        size_d  = mb.data_size;
                        wstrb_d = mb.data_wstrb;
                        addr_d  = mb.data_addr;
                        wdata_d = mb.data_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        size_d  = INST_SIZE;
                        wstrb_d = '0;
                        addr_d  = mb.inst_addr;
                        wdata_d = '0;
                    end
                end
            end
            ADDR: begin
                mb.bus_req      = 1'b1;
                mb.inst_addr_ok = !owner_q && mb.bus_addr_ok;
                mb.data_addr_ok = owner_q && mb.bus_addr_ok;
                if (!owner_q && mb.flush) discard_d = 1'b1;
                if (mb.bus_addr_ok) state_d = DATA;
            end
            DATA: begin
                // A flush coinciding with the response kills it just like an earlier one.
                mb.inst_data_ok = !owner_q && mb.bus_data_ok && !discard_q && !mb.flush;
                mb.data_data_ok = owner_q && mb.bus_data_ok;
                if (!owner_q && mb.flush) discard_d = 1'b1;
                if (mb.bus_data_ok) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mb.bus_wr    = wr_q;
    assign mb.bus_size  = size_q;
    assign mb.bus_wstrb = wstrb_q;
    assign mb.bus_addr  = addr_q;
    assign mb.bus_wdata = wdata_q;
    assign mb.busy      = (state_q != IDLE);

    // Read data is not qualified by data_ok, only held at zero while in reset.
    assign mb.inst_rdata = rst ? mb.bus_rdata : '0;
    assign mb.data_rdata = rst ? mb.bus_rdata : '0;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
    localparam logic [1:0] INST_SIZE  = 2'b10;
    localparam bit         DATA_FIRST = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   rnd_on = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   n_iao = 0, n_ido = 0, n_dao = 0, n_ddo = 0;
    logic [31:0] last_ird = '0, last_drd = '0;

    mem_bus_arbiter_if m ();

    mem_bus_arbiter #(
        .INST_SIZE (INST_SIZE),
        .DATA_FIRST(DATA_FIRST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mb (m)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // One downstream transaction: addr_ok after aw wait cycles, data_ok dw cycles after that.
    task automatic serve(input int aw, input int dw, input logic [31:0] rd, input bit fl,
                         input bit drop_i, input bit drop_d);
        m.bus_addr_ok = 1'b0;
        repeat (aw) sync();
        m.bus_addr_ok = 1'b1;
        sync();
        m.bus_addr_ok = 1'b0;
        if (drop_i) m.inst_req = 1'b0;
        if (drop_d) m.data_req = 1'b0;
        repeat (dw - 1) sync();
        m.bus_data_ok = 1'b1;
        m.bus_rdata   = rd;
        m.flush       = fl;
        sync();
        m.bus_data_ok = 1'b0;
        m.bus_rdata   = '0;
        m.flush       = 1'b0;
    endtask

    // Reference model: the transaction currently holding the bus, if any.
    typedef struct packed {
        logic        who;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t cur;
    bit   m_open = 1'b0, m_acc = 1'b0, m_kill = 1'b0;

    always @(negedge clk) begin : model_chk
        logic [5:0]  e_hs, a_hs;
        logic [70:0] a_bus;
        a_hs  = {m.inst_addr_ok, m.inst_data_ok, m.data_addr_ok, m.data_data_ok, m.bus_req, m.busy};
        a_bus = {m.bus_wr, m.bus_size, m.bus_wstrb, m.bus_addr, m.bus_wdata};
        if (m.inst_addr_ok) n_iao++;
        if (m.data_addr_ok) n_dao++;
        if (m.inst_data_ok) begin n_ido++; last_ird = m.inst_rdata; end
        if (m.data_data_ok) begin n_ddo++; last_drd = m.data_rdata; end
        if (!rst) begin
            m_open = 1'b0;
            m_acc  = 1'b0;
            m_kill = 1'b0;
            chk("reset_handshake", a_hs, 0);
            chk("reset_bus", a_bus, 0);
            chk("reset_rdata", {m.inst_rdata, m.data_rdata}, 0);
        end else begin
            e_hs = {m_open && !m_acc && !cur.who && m.bus_addr_ok,
                    m_open && m_acc && !cur.who && m.bus_data_ok && !m_kill && !m.flush,
                    m_open && !m_acc && cur.who && m.bus_addr_ok,
                    m_open && m_acc && cur.who && m.bus_data_ok,
                    m_open && !m_acc,
                    m_open};
            chk("handshake", a_hs, e_hs);
            if (m_open && !m_acc)
                chk("bus_fields", a_bus, {cur.wr, cur.size, cur.wstrb, cur.addr, cur.wdata});
            chk("rdata", {m.inst_rdata, m.data_rdata}, {m.bus_rdata, m.bus_rdata});
            if (!m_open) begin
                if (m.data_req && (DATA_FIRST || !m.inst_req)) begin
                    cur    = {1'b1, m.data_wr, m.data_size, m.data_wstrb, m.data_addr, m.data_wdata};
                    m_open = 1'b1;
                end else if (m.inst_req) begin
                    cur    = {1'b0, 1'b0, INST_SIZE, 4'b0000, m.inst_addr, 32'h0};
                    m_open = 1'b1;
                end
                m_acc  = 1'b0;
                m_kill = 1'b0;
            end else begin
                if (m.flush && !cur.who) m_kill = 1'b1;
                if (!m_acc) begin
                    if (m.bus_addr_ok) m_acc = 1'b1;
                end else if (m.bus_data_ok) begin
                    m_open = 1'b0;
                end
            end
        end
    end

    // Random traffic: requesters hold until addr_ok, memory answers only what it accepted.
    initial begin : rnd_drv
        bit ia, da, acc, dk, pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            ia  = m.inst_addr_ok;
            da  = m.data_addr_ok;
            acc = m.bus_req && m.bus_addr_ok;
            dk  = m.bus_data_ok;
            @(posedge clk);
            #1;
            if (!rnd_on) begin
                pend = 1'b0;
            end else begin
                if (acc) pend = 1'b1;
                if (dk) pend = 1'b0;
                if (ia) m.inst_req = 1'b0;
                if (da) m.data_req = 1'b0;
                if (!m.inst_req && ($urandom % 3 == 0)) begin
                    m.inst_req  = 1'b1;
                    m.inst_addr = $urandom & 32'hFFFF_FFFC;
                end
                if (!m.data_req && ($urandom % 4 == 0)) begin
                    m.data_req   = 1'b1;
                    m.data_wr    = 1'($urandom % 2);
                    m.data_size  = 2'($urandom_range(0, 2));
                    m.data_wstrb = 4'($urandom);
                    m.data_addr  = $urandom;
                    m.data_wdata = $urandom;
                end
                m.flush       = ($urandom % 6 == 0);
                m.bus_addr_ok = 1'($urandom % 2);
                m.bus_data_ok = pend && ($urandom % 3 == 0);
                m.bus_rdata   = $urandom;
            end
        end
    end

    initial begin : directed
        int prog;
        m.flush       = 1'b0;
        m.inst_req    = 1'b1;
        m.inst_addr   = 32'h0000_1000;
        m.data_req    = 1'b0;
        m.data_wr     = 1'b0;
        m.data_size   = 2'b00;
        m.data_wstrb  = 4'b0000;
        m.data_addr   = '0;
        m.data_wdata  = '0;
        m.bus_addr_ok = 1'b0;
        m.bus_data_ok = 1'b0;
        m.bus_rdata   = '0;
        rst           = 1'b0;

        // Reset held with a pending fetch, then release.
        repeat (3) @(negedge clk);
        chk("rst_busy_busreq", {m.busy, m.bus_req, m.inst_addr_ok}, 0);
        sync();
        rst = 1'b1;
        @(negedge clk);
        chk("t1_bubble", m.bus_req, 0);
        @(negedge clk);
        chk("t1_busreq", m.bus_req, 1);
        chk("t1_addr", m.bus_addr, 32'h0000_1000);
        chk("t1_size", m.bus_size, 2'b10);
        chk("t1_wr", m.bus_wr, 0);
        sync();
        serve(0, 1, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
        chk("t1_inst_data_ok", n_ido, 1);
        chk("t1_inst_rdata", last_ird, 32'h1111_1111);

        // Simultaneous requests: data first, fetch after an IDLE bubble.
        m.inst_req   = 1'b1;
        m.inst_addr  = 32'h0000_2000;
        m.data_req   = 1'b1;
        m.data_wr    = 1'b1;
        m.data_size  = 2'b01;
        m.data_wstrb = 4'b0011;
        m.data_addr  = 32'h8000_0004;
        m.data_wdata = 32'h0000_BEEF;
        sync();
        @(negedge clk);
        chk("t2_data_wins", {m.bus_req, m.bus_wr, m.bus_wstrb, m.bus_addr}, {1'b1, 1'b1, 4'b0011, 32'h8000_0004});
        sync();
        serve(0, 1, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("t2_data_data_ok", n_ddo, 1);
        chk("t2_inst_waits", n_iao, 1);
        @(negedge clk);
        chk("t2_bubble", m.bus_req, 0);
        @(negedge clk);
        chk("t2_inst_next", {m.bus_req, m.bus_addr}, {1'b1, 32'h0000_2000});
        sync();
        serve(0, 1, 32'h2222_2222, 1'b0, 1'b1, 1'b0);
        chk("t2_inst_data_ok", n_ido, 2);

        // Load with slow address acceptance; inputs change after grant but bus stays latched.
        m.data_req   = 1'b1;
        m.data_wr    = 1'b0;
        m.data_size  = 2'b10;
        m.data_wstrb = 4'b1111;
        m.data_addr  = 32'h8000_0100;
        sync();
        m.data_addr  = 32'hFFFF_0000;
        @(negedge clk);
        chk("t3_latched_addr", m.bus_addr, 32'h8000_0100);
        sync();
        serve(2, 2, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        chk("t3_data_addr_ok", n_dao, 2);
        chk("t3_data_data_ok", n_ddo, 2);
        chk("t3_data_rdata", last_drd, 32'hDEAD_BEEF);

        // Flush during the fetch data phase swallows the response.
        m.inst_req  = 1'b1;
        m.inst_addr = 32'h0000_3000;
        sync();
        m.bus_addr_ok = 1'b1;
        sync();
        m.bus_addr_ok = 1'b0;
        m.inst_req    = 1'b0;
        m.flush       = 1'b1;
        sync();
        m.flush = 1'b0;
        sync();
        m.bus_data_ok = 1'b1;
        m.bus_rdata   = 32'h3333_3333;
        sync();
        m.bus_data_ok = 1'b0;
        m.bus_rdata   = '0;
        chk("t4_killed", n_ido, 2);
        @(negedge clk);
        chk("t4_busy_drop", m.busy, 0);
        sync();
        // Flush while IDLE must not mark the next fetch.
        m.inst_req  = 1'b1;
        m.inst_addr = 32'h0000_3004;
        m.flush     = 1'b1;
        sync();
        m.flush = 1'b0;
        serve(1, 1, 32'h4444_4444, 1'b0, 1'b1, 1'b0);
        chk("t4_next_fetch", n_ido, 3);
        chk("t4_next_rdata", last_ird, 32'h4444_4444);

        // Flush coincident with the response: kills fetch, not data.
        m.inst_req  = 1'b1;
        m.inst_addr = 32'h0000_5000;
        sync();
        serve(0, 1, 32'h5555_5555, 1'b1, 1'b1, 1'b0);
        chk("t5_inst_killed", n_ido, 3);
        m.data_req  = 1'b1;
        m.data_wr   = 1'b0;
        m.data_addr = 32'h8000_0200;
        sync();
        serve(0, 1, 32'h6666_6666, 1'b1, 1'b0, 1'b1);
        chk("t5_data_kept", n_ddo, 3);
        chk("t5_data_rdata", last_drd, 32'h6666_6666);

        // Asynchronous reset mid-DATA; a late response is ignored.
        m.data_req  = 1'b1;
        m.data_wr   = 1'b1;
        m.data_addr = 32'h8000_0300;
        sync();
        m.bus_addr_ok = 1'b1;
        sync();
        m.bus_addr_ok = 1'b0;
        m.data_req    = 1'b0;
        sync();
        #2 rst = 1'b0;
        #1;
        chk("t6_async", {m.busy, m.bus_req, m.data_data_ok}, 0);
        sync();
        rst = 1'b1;
        m.bus_data_ok = 1'b1;
        sync();
        m.bus_data_ok = 1'b0;
        chk("t6_no_data_ok", n_ddo, 3);
        chk("t6_addr_oks", n_dao, 4);

        prog   = n_ido + n_ddo;
        rnd_on = 1'b1;
        repeat (4000) @(posedge clk);
        rnd_on = 1'b0;
        #1;
        chk("rnd_progress", (n_ido + n_ddo) > prog + 100, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
